// File: rtl/div_ctrl_if.sv
// EX-stage side of the divide sequencer: request, flush, stall/interlock and HI/LO writeback.
interface div_ctrl_if;
  logic        req_valid;
  logic        req_sign;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  modport master (
    output req_valid, req_sign, req_dividend, req_divisor, flush,
    input  stall, busy, hi_wen, lo_wen, hi_wdata, lo_wdata
  );

  modport slave (
    input  req_valid, req_sign, req_dividend, req_divisor, flush,
    output stall, busy, hi_wen, lo_wen, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer owning the radix-2 divider for DIV/DIVU; stalls EX and writes LO/HI.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the divider and writes in one cycle.
module div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  div_ctrl_if.slave   ex,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divider,
  input  logic        div_ready,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        write;
  logic        stall;
  logic        result_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operands must stay put through the write cycle: the divider's sign fix-up reads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_sign     <= 1'b0;
      div_dividend <= '0;
      div_divider  <= '0;
    end else if (accept) begin
      div_sign     <= ex.req_sign;
      div_dividend <= ex.req_dividend;
      div_divider  <= ex.req_divisor;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  logic bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass <= 1'b0;
    end else if (accept) begin
      bypass <= (ex.req_divisor == 32'd0);
    end
  end

  assign result_ready = bypass | div_ready;
  assign res_hi       = bypass ? div_dividend : div_remainder;
  assign res_lo       = bypass ? 32'hFFFF_FFFF : div_quotient;
`else
  assign result_ready = div_ready;
  assign res_hi       = div_remainder;
  assign res_lo       = div_quotient;
`endif

  // START re-issues div_start until the divider reports idle, covering a unit left running.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    write     = 1'b0;
    stall     = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        if (ex.req_valid && !ex.flush) begin
          accept   = 1'b1;
          stall    = 1'b1;
          state_nx = START;
`ifdef DIV_ZERO_FAST_EN
          if (ex.req_divisor == 32'd0) begin
            state_nx = WAIT;
          end
`endif
        end
      end
      START: begin
        stall     = 1'b1;
        div_start = !ex.flush;
        if (ex.flush) begin
          state_nx = IDLE;
        end else if (div_ready) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (ex.flush) begin
          state_nx = IDLE;
        end else if (result_ready) begin
          write    = 1'b1;
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign ex.stall    = stall;
  assign ex.busy     = (state != IDLE) || accept;
  assign ex.hi_wen   = write;
  assign ex.lo_wen   = write;
  assign ex.hi_wdata = write ? res_hi : 32'd0;
  assign ex.lo_wdata = write ? res_lo : 32'd0;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural 32-cycle, reset-less divider model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_dividend;
  logic [31:0] div_divider;
  logic        div_ready;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  always #5 clk = ~clk;

  div_ctrl_if ex();

  div_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex            (ex),
    .div_start     (div_start),
    .div_sign      (div_sign),
    .div_dividend  (div_dividend),
    .div_divider   (div_divider),
    .div_ready     (div_ready),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Divider: no reset, loads when idle and started, busy for 32 cycles.
  logic [5:0] dcnt = 6'd0;

  always @(posedge clk) begin
    if (dcnt != 6'd0) begin
      dcnt <= dcnt - 6'd1;
    end else if (div_start) begin
      dcnt <= 6'd32;
    end
  end

  assign div_ready = (dcnt == 6'd0);

  function automatic logic [63:0] divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, qm, rm, q, r;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (mb == 32'd0) begin
      qm = 32'hFFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = (sgn && (a[31] ^ b[31])) ? -qm : qm;
    r = (sgn && a[31]) ? -rm : rm;
    return {r, q};
  endfunction

  assign {div_remainder, div_quotient} = divide(div_sign, div_dividend, div_divider);

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every HI/LO write, independent of the stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (div_start) begin
        start_cnt++;
        check_output("start_without_flush", 32'(ex.flush), 32'd0);
      end
      check_output("wen_equal", 32'(ex.hi_wen), 32'(ex.lo_wen));
      if (ex.hi_wen) begin
        check_output("busy_on_write", 32'(ex.busy), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got hi=0x%08h lo=0x%08h, expected no write",
                   ex.hi_wdata, ex.lo_wdata);
        end else begin
          e = sb.pop_front();
          check_output("lo_wdata", ex.lo_wdata, e.lo);
          check_output("hi_wdata", ex.hi_wdata, e.hi);
          check_output("div_dividend_held", div_dividend, e.a);
          check_output("div_divider_held", div_divider, e.b);
        end
      end else begin
        check_output("hi_wdata_idle", ex.hi_wdata, 32'd0);
        check_output("lo_wdata_idle", ex.lo_wdata, 32'd0);
      end
    end
  end

  // Issues one request, holds it while stalled, returns stall length and write cycle.
  task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] lo, input logic [31:0] hi,
                                output int nstall, output int wr_cyc);
    exp_t e;
    @(negedge clk);
    ex.flush        = 1'b0;
    ex.req_valid    = 1'b1;
    ex.req_sign     = sgn;
    ex.req_dividend = a;
    ex.req_divisor  = b;
    e.lo = lo;
    e.hi = hi;
    e.a  = a;
    e.b  = b;
    sb.push_back(e);
    #1;
    nstall = 0;
    while (ex.stall && nstall < 300) begin
      nstall++;
      @(negedge clk);
      #1;
    end
    if (nstall >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL stall_timeout: got stall still high after %0d cycles, expected release", nstall);
    end
    wr_cyc = cyc;
    ex.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_output("rst_stall", 32'(ex.stall), 32'd0);
    check_output("rst_busy", 32'(ex.busy), 32'd0);
    check_output("rst_hi_wen", 32'(ex.hi_wen), 32'd0);
    check_output("rst_lo_wen", 32'(ex.lo_wen), 32'd0);
    check_output("rst_div_start", 32'(div_start), 32'd0);
    check_output("rst_div_sign", 32'(div_sign), 32'd0);
    check_output("rst_div_dividend", div_dividend, 32'd0);
    check_output("rst_div_divider", div_divider, 32'd0);
    check_output("rst_hi_wdata", ex.hi_wdata, 32'd0);
    check_output("rst_lo_wdata", ex.lo_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, w1, w2, exp_n, exp_starts;
    ex.req_valid    = 1'b0;
    ex.req_sign     = 1'b0;
    ex.req_dividend = 32'd0;
    ex.req_divisor  = 32'd0;
    ex.flush        = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] DIVU 100/7");
    start_cnt = 0;
    apply_stimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, n, w1);
    check_output("divu_stall_cycles", 32'(n), 32'd34);
    check_output("divu_start_pulses", 32'(start_cnt), 32'd1);

    $display("[TB] DIV -7/2");
    apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, n, w1);
    check_output("div_stall_cycles", 32'(n), 32'd34);

    $display("[TB] flush mid-divide then DIVU 9/3");
    @(negedge clk);
    ex.req_valid    = 1'b1;
    ex.req_sign     = 1'b0;
    ex.req_dividend = 32'd1000;
    ex.req_divisor  = 32'd3;
    repeat (10) @(negedge clk);
    ex.flush = 1'b1;
    #1;
    check_output("flush_drops_stall", 32'(ex.stall), 32'd0);
    ex.req_valid = 1'b0;
    apply_stimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, n, w1);
    check_output("after_flush_stall_cycles", 32'(n), 32'd56);

    $display("[TB] reset mid-divide then DIVU 50/5");
    repeat (2) @(negedge clk);
    ex.req_valid    = 1'b1;
    ex.req_sign     = 1'b0;
    ex.req_dividend = 32'd77;
    ex.req_divisor  = 32'd7;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    ex.req_valid = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, n, w1);
    check_output("after_reset_stall_cycles", 32'(n), 32'd60);

    $display("[TB] divide by zero");
`ifdef DIV_ZERO_FAST_EN
    exp_n      = 1;
    exp_starts = 0;
`else
    exp_n      = 34;
    exp_starts = 1;
`endif
    repeat (2) @(negedge clk);
    start_cnt = 0;
    apply_stimulus(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, n, w1);
    check_output("divu_zero_stall_cycles", 32'(n), 32'(exp_n));
    check_output("divu_zero_start_pulses", 32'(start_cnt), 32'(exp_starts));
`ifdef DIV_ZERO_FAST_EN
    apply_stimulus(1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, n, w1);
`else
    apply_stimulus(1'b1, 32'hFFFF_FFF0, 32'd0, 32'h0000_0001, 32'hFFFF_FFF0, n, w1);
`endif
    check_output("div_neg_zero_stall_cycles", 32'(n), 32'(exp_n));

    $display("[TB] back-to-back DIVU 8/2, 9/4");
    apply_stimulus(1'b0, 32'd8, 32'd2, 32'd4, 32'd0, n, w1);
    apply_stimulus(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, n, w2);
    check_output("back_to_back_spacing", 32'(w2 - w1), 32'd35);

    repeat (3) @(negedge clk);
    #3;
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer between the EX stage and the 32-iteration radix-2 divider unit. It owns the divider for MIPS DIV/DIVU, latches and holds the operands, and issues the start pulse. It stalls the pipeline for the divide's duration, writes quotient to LO and remainder to HI, and discards results on flush. It tolerates a divider with no reset that may still be busy after a controller reset or flush.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  DIV/DIVU in EX; held stable by pipeline while stall=1
- req_sign  in  1  1 = DIV (signed), 0 = DIVU
- req_dividend  in  32  rs operand
- req_divisor  in  32  rt operand
- flush  in  1  kill in-flight divide (exception/branch squash)
- stall  out  1  freeze pipeline at EX
- busy  out  1  state != IDLE; used to interlock MFHI/MFLO
- hi_wen, lo_wen  out  1 each  HI/LO write strobes, always equal
- hi_wdata  out  32  remainder when hi_wen, else 0
- lo_wdata  out  32  quotient when lo_wen, else 0
- div_start  out  1  divider start
- div_sign, div_dividend, div_divider  out  1/32/32  registered operand copies
- div_ready  in  1  divider idle
- div_quotient, div_remainder  in  32 each  divider results, combinational on div_* operands

## Operation
- States: IDLE, START, WAIT.
- IDLE:
  - req_valid & !flush: latch sign and operands into the div_* registers, assert stall, go to START.
  - Otherwise stay in IDLE.
- START:
  - div_start = !flush; stall=1.
  - flush: go to IDLE.
  - Otherwise, div_ready=1: the divider loads at this edge; go to WAIT.
  - Otherwise, div_ready=0: stay in START. This covers a divider still running from before a reset or flush.
- WAIT:
  - div_start=0.
  - div_ready=0: stall=1.
  - div_ready=1 & !flush: hi_wen=lo_wen=1, stall=0, go to IDLE.
  - flush, any div_ready: no write, stall=0, go to IDLE. The divider may keep counting; the next START waits for it.
- div_* operand registers change only on IDLE accept. They must stay constant through the write cycle, because the divider's sign correction is combinational on them.
- Divide-by-zero (macro absent) goes through the divider. Results:
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV x/0 with x≥0: LO=0xFFFFFFFF, HI=x.
  - DIV x/0 with x<0: LO=0x00000001, HI=x.
- Reset: state=IDLE; div_* registers=0. Outputs stall, busy, hi_wen, lo_wen, div_start are 0, and the data outputs are 0.
- Mid-operation reset: controller returns to IDLE. The next request stalls in START until div_ready=1.

## Timing
- Request seen in IDLE at cycle T, divider idle:
  - T: accept, stall=1.
  - T+1: START, div_start=1; divider loads at the end of this cycle.
  - T+2..T+33: WAIT with div_ready=0.
  - T+34: div_ready=1; write HI/LO, stall=0.
- Stall is high for cycles T..T+33, 34 cycles in total.
- Back-to-back divides: a second request in cycle T+35 is accepted in IDLE. There is no dead cycle beyond the IDLE accept.
- div_start is never high outside START. It is never high while flush=1.
- busy is high T..T+34 with hi_wen in T+34; the MFHI interlock must also honour the write cycle.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - An accepted request with divisor==0 skips the divider.
  - The next cycle writes HI=dividend, LO=0xFFFFFFFF with stall=0. Total 2 cycles; state IDLE→WAIT-bypass→IDLE.
  - div_start is never asserted for it.
  - Flush in that cycle suppresses the write.
- Undefined: divisor==0 takes the full divider path with the results listed under Operation.

## Test plan
- DIVU 100/7 from idle: stall for 34 cycles; single hi_wen/lo_wen pulse at T+34 with LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). div_* operands stay unchanged through the write cycle.
- Flush at T+10 of DIVU 1000/3: no write, stall drops that cycle. A new DIVU 9/3 at T+11 holds in START until div_ready=1 (T+34), then writes LO=3, HI=0.
- rst_n pulsed low at T+5 of a divide, then a new DIVU 50/5: all outputs 0 during reset. div_start is held until the divider's ready rises, then LO=10, HI=0.
- Divisor 0, DIVU 0x12345678: macro absent gives LO=0xFFFFFFFF, HI=0x12345678 after 34 stall cycles. With DIV_ZERO_FAST_EN, the same values after 1 stall cycle and no div_start.
- Back-to-back DIVU 8/2 then 9/4: writes LO=4/HI=0, then LO=2/HI=1, 35 cycles apart.
